// File: rtl/memory_stage_lsu.sv
// Memory stage: execute->memory pipeline register, data-memory request/response FSM,
// store lane replication with byte enables, and load lane selection with extension.
module memory_stage_lsu #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BE_W = XLEN / 8
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            valid_e_i,
  input  logic [XLEN-1:0] alu_result_e_i,
  input  logic [XLEN-1:0] write_data_e_i,
  input  logic [XLEN-1:0] pc_target_e_i,
  input  logic [XLEN-1:0] pc_plus4_e_i,
  input  logic [XLEN-1:0] imm_ext_e_i,
  input  logic [4:0]      rd_e_i,
  input  logic [2:0]      width_src_e_i,
  input  logic [2:0]      result_src_e_i,
  input  logic            mem_read_e_i,
  input  logic            mem_write_e_i,
  input  logic            reg_write_e_i,
  input  logic            stall_m_i,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [BE_W-1:0] dmem_be_o,
  input  logic            dmem_gnt_i,
  input  logic            dmem_rvalid_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            mem_busy_o,
  output logic            misalign_o,
  output logic            valid_m_o,
  output logic [XLEN-1:0] alu_result_m_o,
  output logic [XLEN-1:0] write_data_m_o,
  output logic [XLEN-1:0] pc_target_m_o,
  output logic [XLEN-1:0] pc_plus4_m_o,
  output logic [XLEN-1:0] imm_ext_m_o,
  output logic [4:0]      rd_m_o,
  output logic [2:0]      width_src_m_o,
  output logic [2:0]      result_src_m_o,
  output logic            mem_write_m_o,
  output logic            reg_write_m_o,
  output logic [XLEN-1:0] forward_data_m_o,
  output logic [XLEN-1:0] load_data_m_o
);
  localparam int unsigned OFF_W = $clog2(BE_W);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;

  function automatic size_t dec_size(input logic [2:0] w);
    case (w)
      3'b001, 3'b100: dec_size = SZ_H;
      3'b010, 3'b101: dec_size = SZ_B;
      3'b011:         dec_size = (XLEN == 64) ? SZ_D : SZ_W;
      default:        dec_size = SZ_W;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] low, input size_t sz);
    case (sz)
      SZ_H:    is_misaligned = low[0] != 1'b0;
      SZ_W:    is_misaligned = low[1:0] != 2'b00;
      SZ_D:    is_misaligned = low != 3'b000;
      default: is_misaligned = 1'b0;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              valid_q, mem_read_q, mem_write_q, reg_write_q;
  logic [XLEN-1:0]   alu_q, wdata_q, pct_q, pc4_q, imm_q, load_data_q;
  logic [4:0]        rd_q;
  logic [2:0]        width_q, rsrc_q;

  logic              advance, ld_capture, mis_e, sgn_m;
  size_t             size_m;
  logic [OFF_W-1:0]  off_m;
  logic [BE_W-1:0]   be_base;
  logic [XLEN-1:0]   lane, ld_ext;

  assign mem_busy_o = (state_q == REQ) || (state_q == WAIT);
  assign advance    = ~stall_m_i & ~mem_busy_o;
  assign mis_e      = is_misaligned(alu_result_e_i[2:0], dec_size(width_src_e_i));

  assign size_m     = dec_size(width_q);
  assign sgn_m      = (width_q == 3'b000) || (width_q == 3'b001) || (width_q == 3'b010);
  assign off_m      = alu_q[OFF_W-1:0];
  assign misalign_o = valid_q & (mem_read_q | mem_write_q) & is_misaligned(alu_q[2:0], size_m);

  // A capture always decides the next state; otherwise the handshake proceeds regardless of stall.
  always_comb begin
    state_d    = state_q;
    ld_capture = 1'b0;
    if (advance) begin
      state_d = (valid_e_i & (mem_read_e_i | mem_write_e_i) & ~mis_e) ? REQ : IDLE;
    end else begin
      case (state_q)
        REQ:     if (dmem_gnt_i) state_d = mem_write_q ? DONE : WAIT;
        WAIT:    if (dmem_rvalid_i) begin
                   ld_capture = 1'b1;
                   state_d    = DONE;
                 end
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= IDLE;
      valid_q     <= 1'b0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pct_q       <= '0;
      pc4_q       <= '0;
      imm_q       <= '0;
      rd_q        <= '0;
      width_q     <= '0;
      rsrc_q      <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      reg_write_q <= 1'b0;
      load_data_q <= '0;
    end else begin
      state_q <= state_d;
      if (advance) begin
        valid_q     <= valid_e_i;
        alu_q       <= alu_result_e_i;
        wdata_q     <= write_data_e_i;
        pct_q       <= pc_target_e_i;
        pc4_q       <= pc_plus4_e_i;
        imm_q       <= imm_ext_e_i;
        rd_q        <= rd_e_i;
        width_q     <= width_src_e_i;
        rsrc_q      <= result_src_e_i;
        mem_read_q  <= mem_read_e_i;
        mem_write_q <= mem_write_e_i;
        reg_write_q <= reg_write_e_i;
      end
      if (ld_capture) load_data_q <= ld_ext;
    end
  end

  always_comb begin
    be_base      = '0;
    dmem_wdata_o = wdata_q;
    case (size_m)
      SZ_B: begin
        be_base      = BE_W'(1);
        dmem_wdata_o = {BE_W{wdata_q[7:0]}};
      end
      SZ_H: begin
        be_base      = BE_W'(3);
        dmem_wdata_o = {(BE_W/2){wdata_q[15:0]}};
      end
      SZ_W: begin
        be_base      = BE_W'(4'hF);
        dmem_wdata_o = {(XLEN/32){wdata_q[31:0]}};
      end
      default: begin
        be_base      = '1;
        dmem_wdata_o = wdata_q;
      end
    endcase
  end

  always_comb begin
    lane   = dmem_rdata_i >> {off_m, 3'b000};
    ld_ext = lane;
    case (size_m)
      SZ_B:    ld_ext = sgn_m ? XLEN'($signed(lane[7:0]))  : XLEN'(lane[7:0]);
      SZ_H:    ld_ext = sgn_m ? XLEN'($signed(lane[15:0])) : XLEN'(lane[15:0]);
      SZ_W:    ld_ext = sgn_m ? XLEN'($signed(lane[31:0])) : XLEN'(lane[31:0]);
      default: ld_ext = lane;
    endcase
  end

  always_comb begin
    forward_data_m_o = alu_q;
    case (rsrc_q[1:0])
      2'd1:    forward_data_m_o = pct_q;
      2'd2:    forward_data_m_o = pc4_q;
      2'd3:    forward_data_m_o = imm_q;
      default: forward_data_m_o = alu_q;
    endcase
  end

  assign dmem_req_o     = (state_q == REQ);
  assign dmem_we_o      = mem_write_q;
  assign dmem_addr_o    = alu_q;
  assign dmem_be_o      = be_base << off_m;
  assign valid_m_o      = valid_q;
  assign alu_result_m_o = alu_q;
  assign write_data_m_o = wdata_q;
  assign pc_target_m_o  = pct_q;
  assign pc_plus4_m_o   = pc4_q;
  assign imm_ext_m_o    = imm_q;
  assign rd_m_o         = rd_q;
  assign width_src_m_o  = width_q;
  assign result_src_m_o = rsrc_q;
  assign mem_write_m_o  = mem_write_q;
  assign reg_write_m_o  = reg_write_q & ~misalign_o;
  assign load_data_m_o  = load_data_q;
endmodule

// File: tb/tb_memory_stage_lsu.sv
// Bench for memory_stage_lsu: 32-bit instance for the main handshake scenarios,
// 64-bit instance for dword and upper-lane loads.
module tb_memory_stage_lsu;
  logic        clk = 1'b0;
  logic        reset_i = 1'b1;
  logic        valid_e_i = 1'b0;
  logic [31:0] alu_result_e_i = '0, write_data_e_i = '0, pc_target_e_i = '0, pc_plus4_e_i = '0, imm_ext_e_i = '0;
  logic [4:0]  rd_e_i = '0;
  logic [2:0]  width_src_e_i = '0, result_src_e_i = '0;
  logic        mem_read_e_i = 1'b0, mem_write_e_i = 1'b0, reg_write_e_i = 1'b0, stall_m_i = 1'b0;
  logic        dmem_req_o, dmem_we_o, dmem_gnt_i = 1'b0, dmem_rvalid_i = 1'b0;
  logic [31:0] dmem_addr_o, dmem_wdata_o, dmem_rdata_i = '0;
  logic [3:0]  dmem_be_o;
  logic        mem_busy_o, misalign_o, valid_m_o, mem_write_m_o, reg_write_m_o;
  logic [31:0] alu_result_m_o, write_data_m_o, pc_target_m_o, pc_plus4_m_o, imm_ext_m_o;
  logic [31:0] forward_data_m_o, load_data_m_o;
  logic [4:0]  rd_m_o;
  logic [2:0]  width_src_m_o, result_src_m_o;

  logic        w_valid_e = 1'b0, w_mem_read = 1'b0, w_reg_write = 1'b0;
  logic [63:0] w_alu_e = '0, w_rdata = '0;
  logic [2:0]  w_width_e = '0;
  logic        w_gnt = 1'b0, w_rvalid = 1'b0;
  logic        w_req, w_we, w_busy, w_misalign, w_valid_m, w_mem_write_m, w_reg_write_m;
  logic [63:0] w_addr, w_wdata, w_alu_m, w_wd_m, w_pct_m, w_pc4_m, w_imm_m, w_fwd, w_load;
  logic [7:0]  w_be;
  logic [4:0]  w_rd_m;
  logic [2:0]  w_width_m, w_rsrc_m;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } exp_req_t;

  exp_req_t    req_q[$];
  logic [31:0] load_q[$];
  logic [63:0] load64_q[$];

  always #5 clk = ~clk;

  memory_stage_lsu #(.XLEN(32)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_e_i(valid_e_i),
    .alu_result_e_i(alu_result_e_i), .write_data_e_i(write_data_e_i),
    .pc_target_e_i(pc_target_e_i), .pc_plus4_e_i(pc_plus4_e_i), .imm_ext_e_i(imm_ext_e_i),
    .rd_e_i(rd_e_i), .width_src_e_i(width_src_e_i), .result_src_e_i(result_src_e_i),
    .mem_read_e_i(mem_read_e_i), .mem_write_e_i(mem_write_e_i), .reg_write_e_i(reg_write_e_i),
    .stall_m_i(stall_m_i), .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
    .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i),
    .mem_busy_o(mem_busy_o), .misalign_o(misalign_o), .valid_m_o(valid_m_o),
    .alu_result_m_o(alu_result_m_o), .write_data_m_o(write_data_m_o),
    .pc_target_m_o(pc_target_m_o), .pc_plus4_m_o(pc_plus4_m_o), .imm_ext_m_o(imm_ext_m_o),
    .rd_m_o(rd_m_o), .width_src_m_o(width_src_m_o), .result_src_m_o(result_src_m_o),
    .mem_write_m_o(mem_write_m_o), .reg_write_m_o(reg_write_m_o),
    .forward_data_m_o(forward_data_m_o), .load_data_m_o(load_data_m_o)
  );

  memory_stage_lsu #(.XLEN(64)) dut64 (
    .clk_i(clk), .reset_i(reset_i), .valid_e_i(w_valid_e),
    .alu_result_e_i(w_alu_e), .write_data_e_i(64'd0),
    .pc_target_e_i(64'd0), .pc_plus4_e_i(64'd0), .imm_ext_e_i(64'd0),
    .rd_e_i(5'd3), .width_src_e_i(w_width_e), .result_src_e_i(3'd0),
    .mem_read_e_i(w_mem_read), .mem_write_e_i(1'b0), .reg_write_e_i(w_reg_write),
    .stall_m_i(1'b0), .dmem_req_o(w_req), .dmem_we_o(w_we),
    .dmem_addr_o(w_addr), .dmem_wdata_o(w_wdata), .dmem_be_o(w_be),
    .dmem_gnt_i(w_gnt), .dmem_rvalid_i(w_rvalid), .dmem_rdata_i(w_rdata),
    .mem_busy_o(w_busy), .misalign_o(w_misalign), .valid_m_o(w_valid_m),
    .alu_result_m_o(w_alu_m), .write_data_m_o(w_wd_m),
    .pc_target_m_o(w_pct_m), .pc_plus4_m_o(w_pc4_m), .imm_ext_m_o(w_imm_m),
    .rd_m_o(w_rd_m), .width_src_m_o(w_width_m), .result_src_m_o(w_rsrc_m),
    .mem_write_m_o(w_mem_write_m), .reg_write_m_o(w_reg_write_m),
    .forward_data_m_o(w_fwd), .load_data_m_o(w_load)
  );

  task automatic clear_e();
    valid_e_i = 1'b0; mem_read_e_i = 1'b0; mem_write_e_i = 1'b0; reg_write_e_i = 1'b0;
  endtask

  // Presents one instruction for a single capture edge, then withdraws it.
  task automatic issue(input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] width,
                       input logic rd_en, input logic wr_en, input logic [3:0] exp_be,
                       input logic [31:0] exp_wd, input bit expect_req);
    exp_req_t e;
    @(negedge clk);
    valid_e_i = 1'b1; alu_result_e_i = addr; write_data_e_i = wd; width_src_e_i = width;
    mem_read_e_i = rd_en; mem_write_e_i = wr_en; reg_write_e_i = rd_en;
    rd_e_i = 5'd9; result_src_e_i = 3'd0;
    e.addr = addr; e.we = wr_en; e.be = exp_be; e.wdata = exp_wd;
    if (expect_req) req_q.push_back(e);
    @(posedge clk); #1;
    clear_e();
  endtask

  // Memory responder: grants on the (gnt_wait+1)-th request cycle, answers a load one cycle later.
  task automatic run_mem(input int gnt_wait, input logic [31:0] rdata, output int busy_n, output int req_n);
    exp_req_t er;
    bit have_er, granted, done;
    int g, k;
    busy_n = 0; req_n = 0; have_er = 0; granted = 0; done = 0; g = 0; k = 0;
    er = '0;
    for (int t = 0; t < 40 && !done; t++) begin
      @(negedge clk);
      dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = 32'h7EAD_BEEF;
      if (mem_busy_o) busy_n++;
      if (granted) k++;
      if (granted && !mem_busy_o) begin
        done = 1;
      end else if (dmem_req_o) begin
        req_n++;
        if (!have_er && req_q.size() > 0) begin er = req_q.pop_front(); have_er = 1; end
        if (have_er) begin
          checks++;
          if ({dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o} !== {er.addr, er.we, er.be, er.wdata}) begin
            errors++;
            $display("FAIL req_fields: got addr=%h we=%b be=%b wdata=%h want addr=%h we=%b be=%b wdata=%h",
                     dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o, er.addr, er.we, er.be, er.wdata);
          end
        end
        if (g == gnt_wait) begin
          dmem_gnt_i = 1'b1; dmem_rvalid_i = 1'b1; granted = 1;
        end
        g++;
      end else if (granted && k == 1) begin
        dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
      end
    end
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout: got no completion within 40 cycles, want completion");
    end
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++;
    if ({dmem_req_o, mem_busy_o, misalign_o, valid_m_o, reg_write_m_o, mem_write_m_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got req=%b busy=%b mis=%b valid=%b rw=%b mw=%b want all 0",
               dmem_req_o, mem_busy_o, misalign_o, valid_m_o, reg_write_m_o, mem_write_m_o);
    end
    checks++;
    if ({load_data_m_o, alu_result_m_o, forward_data_m_o} !== 96'd0) begin
      errors++;
      $display("FAIL reset_data: got ld=%h alu=%h fwd=%h want 0", load_data_m_o, alu_result_m_o, forward_data_m_o);
    end
    reset_i = 1'b0;
  endtask

  task automatic test_forward();
    logic [31:0] exp_f;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      valid_e_i = 1'b1; reg_write_e_i = 1'b1; rd_e_i = 5'(i + 1); result_src_e_i = 3'(i);
      alu_result_e_i = 32'h1100_0000 + i; pc_target_e_i = 32'h2200_0000 + i;
      pc_plus4_e_i = 32'h3300_0000 + i; imm_ext_e_i = 32'h4400_0000 + i;
      exp_f = (i == 0) ? 32'h1100_0000 : (i == 1) ? 32'h2200_0001 : (i == 2) ? 32'h3300_0002 : 32'h4400_0003;
      @(negedge clk);
      checks++;
      if (forward_data_m_o !== exp_f || rd_m_o !== 5'(i + 1) || reg_write_m_o !== 1'b1 || dmem_req_o !== 1'b0) begin
        errors++;
        $display("FAIL forward_sel%0d: got fwd=%h rd=%0d rw=%b req=%b want fwd=%h rd=%0d rw=1 req=0",
                 i, forward_data_m_o, rd_m_o, reg_write_m_o, dmem_req_o, exp_f, i + 1);
      end
    end
    clear_e();
  endtask

  task automatic test_loads();
    logic [31:0] va[7], vr[7], vl[7], got;
    logic [2:0]  vw[7];
    logic [3:0]  vb[7];
    int bn, rn;
    va = '{32'h1003, 32'h1001, 32'h1002, 32'h1000, 32'h1000, 32'h1000, 32'h1000};
    vw = '{3'b010, 3'b101, 3'b001, 3'b100, 3'b000, 3'b110, 3'b011};
    vb = '{4'b1000, 4'b0010, 4'b1100, 4'b0011, 4'b1111, 4'b1111, 4'b1111};
    vl = '{32'hFFFF_FF80, 32'h0000_0055, 32'hFFFF_80AA, 32'h0000_5511, 32'h80AA_5511, 32'h80AA_5511, 32'h80AA_5511};
    vr = '{default: 32'h80AA_5511};
    for (int i = 0; i < 7; i++) begin
      load_q.push_back(vl[i]);
      issue(va[i], 32'd0, vw[i], 1'b1, 1'b0, vb[i], 32'd0, 1);
      run_mem(0, vr[i], bn, rn);
      checks++;
      if (bn != 2 || rn != 1) begin
        errors++;
        $display("FAIL load%0d_timing: got busy=%0d req=%0d want busy=2 req=1", i, bn, rn);
      end
      got = load_q.pop_front();
      checks++;
      if (load_data_m_o !== got || reg_write_m_o !== 1'b1 || misalign_o !== 1'b0) begin
        errors++;
        $display("FAIL load%0d_data: got ld=%h rw=%b mis=%b want ld=%h rw=1 mis=0",
                 i, load_data_m_o, reg_write_m_o, misalign_o, got);
      end
    end
  endtask

  task automatic test_stores();
    logic [31:0] va[3], vd[3], ve[3];
    logic [2:0]  vw[3];
    logic [3:0]  vb[3];
    int          vg[3];
    int bn, rn;
    va = '{32'h2002, 32'h2001, 32'h2004};
    vw = '{3'b001, 3'b010, 3'b000};
    vd = '{32'h0000_BEEF, 32'h1234_5678, 32'hCAFE_F00D};
    vb = '{4'b1100, 4'b0010, 4'b1111};
    ve = '{32'hBEEF_BEEF, 32'h7878_7878, 32'hCAFE_F00D};
    vg = '{2, 0, 1};
    for (int i = 0; i < 3; i++) begin
      issue(va[i], vd[i], vw[i], 1'b0, 1'b1, vb[i], ve[i], 1);
      run_mem(vg[i], 32'h0, bn, rn);
      checks++;
      if (bn != vg[i] + 1 || rn != vg[i] + 1 || mem_write_m_o !== 1'b1) begin
        errors++;
        $display("FAIL store%0d_timing: got busy=%0d req=%0d mw=%b want busy=%0d req=%0d mw=1",
                 i, bn, rn, mem_write_m_o, vg[i] + 1, vg[i] + 1);
      end
    end
  endtask

  task automatic test_misalign();
    logic [31:0] va[2];
    logic [2:0]  vw[2];
    va = '{32'h3001, 32'h3005};
    vw = '{3'b000, 3'b100};
    for (int i = 0; i < 2; i++) begin
      issue(va[i], 32'd0, vw[i], 1'b1, 1'b0, 4'b0, 32'd0, 0);
      stall_m_i = 1'b1;
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        checks++;
        if ({misalign_o, reg_write_m_o, dmem_req_o, mem_busy_o} !== 4'b1000) begin
          errors++;
          $display("FAIL misalign%0d_c%0d: got mis=%b rw=%b req=%b busy=%b want mis=1 rw=0 req=0 busy=0",
                   i, c, misalign_o, reg_write_m_o, dmem_req_o, mem_busy_o);
        end
      end
      stall_m_i = 1'b0;
    end
  endtask

  task automatic test_stall();
    int bn, rn;
    logic [31:0] got;
    load_q.push_back(32'h0BAD_CAFE);
    issue(32'h4000, 32'd0, 3'b000, 1'b1, 1'b0, 4'b1111, 32'd0, 1);
    stall_m_i = 1'b1;
    run_mem(0, 32'h0BAD_CAFE, bn, rn);
    got = load_q.pop_front();
    checks++;
    if (bn != 2 || load_data_m_o !== got) begin
      errors++;
      $display("FAIL stall_handshake: got busy=%0d ld=%h want busy=2 ld=%h", bn, load_data_m_o, got);
    end
    valid_e_i = 1'b1; alu_result_e_i = 32'h4444; rd_e_i = 5'd7; result_src_e_i = 3'd0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (alu_result_m_o !== 32'h4000 || rd_m_o !== 5'd9 || mem_busy_o !== 1'b0 || load_data_m_o !== got) begin
        errors++;
        $display("FAIL stall_hold%0d: got alu=%h rd=%0d busy=%b ld=%h want alu=4000 rd=9 busy=0 ld=%h",
                 c, alu_result_m_o, rd_m_o, mem_busy_o, load_data_m_o, got);
      end
    end
    stall_m_i = 1'b0;
    @(negedge clk);
    checks++;
    if (alu_result_m_o !== 32'h4444 || rd_m_o !== 5'd7 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL stall_release: got alu=%h rd=%0d req=%b want alu=4444 rd=7 req=0", alu_result_m_o, rd_m_o, dmem_req_o);
    end
    clear_e();
  endtask

  task automatic test_reset_req();
    issue(32'h5000, 32'd0, 3'b000, 1'b1, 1'b0, 4'b0, 32'd0, 0);
    @(negedge clk);
    checks++;
    if (dmem_req_o !== 1'b1) begin
      errors++;
      $display("FAIL rstreq_pre: got req=%b want 1", dmem_req_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    checks++;
    if (dmem_req_o !== 1'b0 || mem_busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstreq_drop: got req=%b busy=%b want 0 0", dmem_req_o, mem_busy_o);
    end
  endtask

  task automatic test_reset_wait();
    issue(32'h5004, 32'd0, 3'b000, 1'b1, 1'b0, 4'b0, 32'd0, 0);
    @(negedge clk);
    dmem_gnt_i = 1'b1;
    @(negedge clk);
    dmem_gnt_i = 1'b0;
    checks++;
    if (mem_busy_o !== 1'b1 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL rstwait_pre: got busy=%b req=%b want busy=1 req=0", mem_busy_o, dmem_req_o);
    end
    reset_i = 1'b1;
    @(negedge clk);
    reset_i = 1'b0;
    @(negedge clk);
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1234_5678;
    @(negedge clk);
    dmem_rvalid_i = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (load_data_m_o !== 32'd0 || mem_busy_o !== 1'b0 || dmem_req_o !== 1'b0 || valid_m_o !== 1'b0) begin
        errors++;
        $display("FAIL rstwait_late_rvalid%0d: got ld=%h busy=%b req=%b valid=%b want ld=0 busy=0 req=0 valid=0",
                 c, load_data_m_o, mem_busy_o, dmem_req_o, valid_m_o);
      end
    end
  endtask

  task automatic test_dword64();
    logic [63:0] va[3], vr[3], vl[3], got;
    logic [2:0]  vw[3];
    logic [7:0]  vb[3];
    va = '{64'h8, 64'h4, 64'h6};
    vw = '{3'b011, 3'b000, 3'b101};
    vr = '{64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001, 64'h00AB_0000_0000_0000};
    vb = '{8'hFF, 8'hF0, 8'h40};
    vl = '{64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000, 64'h0000_0000_0000_00AB};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      w_valid_e = 1'b1; w_alu_e = va[i]; w_width_e = vw[i]; w_mem_read = 1'b1; w_reg_write = 1'b1;
      load64_q.push_back(vl[i]);
      @(posedge clk); #1;
      w_valid_e = 1'b0; w_mem_read = 1'b0; w_reg_write = 1'b0;
      @(negedge clk);
      checks++;
      if (w_req !== 1'b1 || w_be !== vb[i] || w_addr !== va[i] || w_misalign !== 1'b0) begin
        errors++;
        $display("FAIL x64_req%0d: got req=%b be=%h addr=%h mis=%b want req=1 be=%h addr=%h mis=0",
                 i, w_req, w_be, w_addr, w_misalign, vb[i], va[i]);
      end
      w_gnt = 1'b1;
      @(negedge clk);
      w_gnt = 1'b0; w_rvalid = 1'b1; w_rdata = vr[i];
      @(negedge clk);
      w_rvalid = 1'b0;
      got = load64_q.pop_front();
      checks++;
      if (w_busy !== 1'b0 || w_load !== got || w_reg_write_m !== 1'b1) begin
        errors++;
        $display("FAIL x64_load%0d: got busy=%b ld=%h rw=%b want busy=0 ld=%h rw=1", i, w_busy, w_load, w_reg_write_m, got);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000, want earlier finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_forward();
    test_loads();
    test_stores();
    test_misalign();
    test_stall();
    test_reset_req();
    test_reset_wait();
    test_dword64();
    checks++;
    if (req_q.size() != 0 || load_q.size() != 0 || load64_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got req=%0d ld=%0d ld64=%0d left want 0", req_q.size(), load_q.size(), load64_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/memory_stage_lsu.md
MEMORY_STAGE_LSU -- requirements
Module: memory_stage_lsu

Interface
REQ-001 Parameter XLEN, default 32, SHALL set the datapath width; legal values are 32 and 64.
REQ-002 Parameter BE_W, default XLEN/8, SHALL set the byte-enable width.
REQ-003 The block SHALL use one clock, clk_i, and reset_i SHALL be synchronous and active-high.
REQ-004 Ports SHALL be, in order (name, direction, width, meaning):
- clk_i  in  1  clock
- reset_i  in  1  synchronous active-high reset
- valid_e_i  in  1  execute-stage instruction valid
- alu_result_e_i, write_data_e_i, pc_target_e_i, pc_plus4_e_i, imm_ext_e_i  in  XLEN each  execute data
- rd_e_i  in  5  destination register
- width_src_e_i, result_src_e_i  in  3 each  access width and result select
- mem_read_e_i, mem_write_e_i, reg_write_e_i  in  1 each  control
- stall_m_i  in  1  downstream/hazard stall
- dmem_req_o  out  1  memory request
- dmem_we_o  out  1  store
- dmem_addr_o, dmem_wdata_o  out  XLEN  address, lane-replicated store data
- dmem_be_o  out  BE_W  byte enables
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  load response valid
- dmem_rdata_i  in  XLEN  load response data
- mem_busy_o  out  1  stall request to hazard unit
- misalign_o  out  1  held instruction is misaligned
- valid_m_o, alu_result_m_o, write_data_m_o, pc_target_m_o, pc_plus4_m_o, imm_ext_m_o, rd_m_o, width_src_m_o, result_src_m_o, mem_write_m_o, reg_write_m_o  out  registered memory-stage copies
- forward_data_m_o  out  XLEN  forwarding value
- load_data_m_o  out  XLEN  reduced and extended load data

Function
REQ-005 advance = ~stall_m_i & ~mem_busy_o; the pipeline register SHALL capture all *_e_i inputs on an edge where advance=1, and SHALL hold otherwise.
REQ-006 width_src encoding SHALL be: 000 word signed, 001 half signed, 010 byte signed, 100 half unsigned, 101 byte unsigned, 110 word unsigned, 011 dword. When XLEN=32, 110 and 011 SHALL behave as word.
REQ-007 misalign_o SHALL be set when the held instruction is a valid access with half and addr[0]!=0, word and addr[1:0]!=0, or dword and addr[2:0]!=0.
REQ-008 While misalign_o=1, reg_write_m_o SHALL be 0 and no request SHALL issue.
REQ-009 The FSM SHALL have states IDLE, REQ, WAIT, DONE.
- After a capture of a valid, aligned read or write: REQ; after any other capture: IDLE.
- REQ: dmem_req_o=1. On dmem_gnt_i, a store goes to DONE and a load goes to WAIT.
- WAIT: on dmem_rvalid_i, capture load_data_m_o and go to DONE.
- DONE: hold until advance.
REQ-010 mem_busy_o SHALL be 1 exactly in REQ and WAIT.
REQ-011 dmem_addr_o, dmem_we_o, dmem_be_o and dmem_wdata_o SHALL be stable while dmem_req_o=1 and dmem_gnt_i=0.
REQ-012 dmem_rvalid_i SHALL be ignored outside WAIT, including in the same cycle as dmem_gnt_i.
REQ-013 stall_m_i SHALL NOT suspend an in-flight handshake; it only blocks advance.
REQ-014 dmem_be_o SHALL be: byte = 1<<addr low bits; half = 2'b11 shifted by addr; word = 4'hF shifted; dword = all ones. dmem_wdata_o SHALL replicate the low byte, half or word across all lanes.
REQ-015 load_data_m_o SHALL select the addressed lane of dmem_rdata_i, then sign- or zero-extend it per width_src_m_o.
REQ-016 forward_data_m_o SHALL select by result_src_m_o[1:0]: 0 alu_result, 1 pc_target, 2 pc_plus4, 3 imm_ext.
REQ-017 Minimum load latency SHALL be: capture at edge N, REQ with gnt in cycle N+1, rvalid in cycle N+2, DONE in cycle N+3. mem_busy_o is high for 2 cycles.

Reset
REQ-018 On reset_i, the FSM SHALL go to IDLE, and all registered outputs, dmem_req_o, mem_busy_o, misalign_o and load_data_m_o SHALL be 0.
REQ-019 Reset in REQ or WAIT SHALL drop dmem_req_o on the next cycle; any later rvalid from the aborted access SHALL be ignored.

Verification
REQ-020 Load byte signed, addr=0x1003, rdata=0x80AA5511, gnt immediate, rvalid +1 -> be=4'b1000, load_data=0xFFFFFF80, busy high 2 cycles.
REQ-021 Store half, addr=0x2002, wdata=0x0000BEEF, gnt after 3 cycles -> req held 3 cycles with stable outputs, be=4'b1100, wdata=0xBEEFBEEF, no WAIT.
REQ-022 Load word at addr=0x3001 -> misalign_o=1, reg_write_m_o=0, no dmem_req_o, busy=0.
REQ-023 stall_m_i=1 throughout a load -> handshake completes, state DONE, outputs held until stall releases, then next instruction is captured.
REQ-024 reset_i asserted in WAIT, then rvalid arrives 2 cycles later -> IDLE, load_data stays 0, no state change.
REQ-025 XLEN=64, dword load at addr=0x8, rdata=0x8000000000000001 -> be=8'hFF, load_data unchanged.
